// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared constants for the game sequencer and the 20x15
//                space-shooter core: FSM state encoding, playfield size and
//                spawn LFSR constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Display-visible state encoding.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSE     = 3'd3;
  localparam logic [2:0] ST_OVER      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_COUNTDOWN = ST_COUNTDOWN,
    S_PLAY      = ST_PLAY,
    S_PAUSE     = ST_PAUSE,
    S_OVER      = ST_OVER
  } state_t;

  // Playfield geometry shared with the core.
  localparam int PF_COLS = 20;
  localparam int PF_ROWS = 15;

  // Fibonacci LFSR: feedback is the XOR of bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage : game_pkg
`default_nettype wire

// File: rtl/game_sequencer_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_scheduler
//  Description : Level-scaled enemy spawn timer. An interval counter runs
//                while enabled and fires a one-cycle spawn pulse each time it
//                reaches the current interval; the spawn column comes from a
//                free-running 8-bit LFSR folded into 0..COLS-1.
//  Ports       : clk, rst        - clock, async active-high reset
//                i_enable        - counting allowed (game stays in PLAY)
//                i_level         - current level, selects the interval
//                i_clear         - restart the interval from zero
//                o_spawn_req     - registered one-cycle spawn pulse
//                o_spawn_x       - registered spawn column
//  Revision    : 1.0 - initial release
// ============================================================================
module spawn_scheduler
  import game_pkg::*;
#(
  parameter int COLS          = PF_COLS,
  parameter int BASE_INTERVAL = 40,
  parameter int INTERVAL_STEP = 4,
  parameter int MIN_INTERVAL  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [3:0] i_level,
  input  logic       i_clear,
  output logic       o_spawn_req,
  output logic [4:0] o_spawn_x
);

  logic [15:0] r_cnt;
  logic [7:0]  r_lfsr;
  logic        r_spawn_req;
  logic [4:0]  r_spawn_x;

  logic [15:0] w_step;
  logic [15:0] w_sub;
  logic [15:0] w_cur;
  logic        w_fire;
  logic        w_fb;
  logic [4:0]  w_raw;
  logic [4:0]  w_fold;

  // Saturating subtract so high levels never wrap to a huge interval,
  // then clamp to the floor.
  assign w_step = 16'(i_level) * 16'(INTERVAL_STEP);
  assign w_sub  = (16'(BASE_INTERVAL) > w_step) ? (16'(BASE_INTERVAL) - w_step) : 16'd0;
  assign w_cur  = (w_sub < 16'(MIN_INTERVAL)) ? 16'(MIN_INTERVAL) : w_sub;

  // ">=" rather than "==": a level-up can shrink the interval below the
  // value already counted, which must fire at once instead of wrapping.
  assign w_fire = i_enable && (r_cnt >= (w_cur - 16'd1));

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign w_raw  = r_lfsr[4:0];
  assign w_fold = (w_raw < 5'(COLS)) ? w_raw : (w_raw - 5'(COLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_spawn_req <= 1'b0;
      r_spawn_x   <= '0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      if (i_clear) begin
        r_cnt       <= '0;
        r_spawn_req <= 1'b0;
      end else if (w_fire) begin
        r_cnt       <= '0;
        r_spawn_req <= 1'b1;
        r_spawn_x   <= w_fold;
      end else begin
        r_spawn_req <= 1'b0;
        if (i_enable) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign o_spawn_req = r_spawn_req;
  assign o_spawn_x   = r_spawn_x;

endmodule : spawn_scheduler
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Game flow controller for the space-shooter core. Runs the
//                IDLE/COUNTDOWN/PLAY/PAUSE/OVER machine, tracks lives and
//                level, gates the core's reset/run and drives its spawn port.
//  Ports       : clk, rst            - clock, async active-high reset
//                start_btn, pause_btn- level buttons, rising edge acts
//                hit, enemy_escape   - one-cycle pulses from the core
//                core_rst_n, core_run- core hold / movement enable
//                spawn_req/x/y       - enemy spawn port of the core
//                state, lives, level - display status
//                game_over           - high while in OVER
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
  import game_pkg::*;
#(
  parameter int COLS           = PF_COLS,
  parameter int START_LIVES    = 3,
  parameter int HITS_PER_LEVEL = 5,
  parameter int BASE_INTERVAL  = 40,
  parameter int INTERVAL_STEP  = 4,
  parameter int MIN_INTERVAL   = 8,
  parameter int COUNTDOWN_CYC  = 16,
  parameter int MAX_LEVEL      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       hit,
  input  logic       enemy_escape,
  output logic       core_rst_n,
  output logic       core_run,
  output logic       spawn_req,
  output logic [4:0] spawn_x,
  output logic [3:0] spawn_y,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic       game_over
);

  state_t      r_state;
  logic        r_start_prev;
  logic        r_pause_prev;
  logic [2:0]  r_lives;
  logic [3:0]  r_level;
  logic [7:0]  r_hits;
  logic [15:0] r_cd;
  logic        r_core_rst_n;
  logic        r_core_run;
  logic        r_game_over;

  state_t      w_state_nxt;
  logic [2:0]  w_lives_nxt;
  logic [3:0]  w_level_nxt;
  logic [7:0]  w_hits_nxt;
  logic [15:0] w_cd_nxt;
  logic        w_init;
  logic        w_start_press;
  logic        w_pause_press;
  logic        w_sched_en;

  assign w_start_press = start_btn & ~r_start_prev;
  assign w_pause_press = pause_btn & ~r_pause_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_level_nxt = r_level;
    w_hits_nxt  = r_hits;
    w_cd_nxt    = r_cd;
    w_init      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_press) w_init = 1'b1;
      end
      S_COUNTDOWN: begin
        if (w_start_press) begin
          w_init = 1'b1;
        end else if (r_cd == 16'(COUNTDOWN_CYC - 1)) begin
          w_state_nxt = S_PLAY;
        end else begin
          w_cd_nxt = r_cd + 16'd1;
        end
      end
      S_PLAY: begin
        if (w_pause_press) w_state_nxt = S_PAUSE;
        if (hit) begin
          if (r_hits == 8'(HITS_PER_LEVEL - 1)) begin
            w_hits_nxt = '0;
            if (r_level < 4'(MAX_LEVEL)) w_level_nxt = r_level + 4'd1;
          end else begin
            w_hits_nxt = r_hits + 8'd1;
          end
        end
        // Last-life escape overrides a same-cycle pause; level update above
        // is still committed.
        if (enemy_escape) begin
          if (r_lives <= 3'd1) begin
            w_lives_nxt = '0;
            w_state_nxt = S_OVER;
          end else begin
            w_lives_nxt = r_lives - 3'd1;
          end
        end
      end
      S_PAUSE: begin
        if (w_pause_press) w_state_nxt = S_PLAY;
      end
      S_OVER: begin
        if (w_start_press) w_init = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_init) begin
      w_state_nxt = S_COUNTDOWN;
      w_lives_nxt = 3'(START_LIVES);
      w_level_nxt = '0;
      w_hits_nxt  = '0;
      w_cd_nxt    = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
      r_lives      <= '0;
      r_level      <= '0;
      r_hits       <= '0;
      r_cd         <= '0;
      r_core_rst_n <= 1'b0;
      r_core_run   <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_prev <= start_btn;
      r_pause_prev <= pause_btn;
      r_lives      <= w_lives_nxt;
      r_level      <= w_level_nxt;
      r_hits       <= w_hits_nxt;
      r_cd         <= w_cd_nxt;
      r_core_rst_n <= (w_state_nxt != S_IDLE);
      r_core_run   <= (w_state_nxt == S_PLAY);
      r_game_over  <= (w_state_nxt == S_OVER);
    end
  end

  // Count only in cycles that stay in PLAY, so a spawn can never land in the
  // first cycle of PAUSE or OVER.
  assign w_sched_en = (r_state == S_PLAY) && (w_state_nxt == S_PLAY);

  spawn_scheduler #(
    .COLS          (COLS),
    .BASE_INTERVAL (BASE_INTERVAL),
    .INTERVAL_STEP (INTERVAL_STEP),
    .MIN_INTERVAL  (MIN_INTERVAL)
  ) u_spawn (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (w_sched_en),
    .i_level     (r_level),
    .i_clear     (w_init),
    .o_spawn_req (spawn_req),
    .o_spawn_x   (spawn_x)
  );

  assign spawn_y    = 4'd0;
  assign state      = r_state;
  assign lives      = r_lives;
  assign level      = r_level;
  assign core_rst_n = r_core_rst_n;
  assign core_run   = r_core_run;
  assign game_over  = r_game_over;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Self-checking bench for game_sequencer: directed scenarios
//                plus random button/hit/escape traffic compared every cycle
//                against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  localparam int C_COLS  = 20;
  localparam int C_LIVES = 3;
  localparam int C_HPL   = 5;
  localparam int C_BASE  = 40;
  localparam int C_STEP  = 4;
  localparam int C_MIN   = 8;
  localparam int C_CD    = 16;
  localparam int C_MAXL  = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, pause_btn, hit, enemy_escape;
  logic       core_rst_n, core_run, spawn_req, game_over;
  logic [4:0] spawn_x;
  logic [3:0] spawn_y, level;
  logic [2:0] state, lives;

  game_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .hit          (hit),
    .enemy_escape (enemy_escape),
    .core_rst_n   (core_rst_n),
    .core_run     (core_run),
    .spawn_req    (spawn_req),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .state        (state),
    .lives        (lives),
    .level        (level),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model (0=IDLE 1=CD 2=PLAY 3=PAUSE 4=OVER)
  int m_st, m_lives, m_level, m_hits, m_cd, m_cnt, m_lfsr, m_sx;
  bit m_req, m_ps, m_pp;

  task automatic model_reset();
    m_st = 0; m_lives = 0; m_level = 0; m_hits = 0; m_cd = 0; m_cnt = 0;
    m_lfsr = 'hA5; m_sx = 0; m_req = 0; m_ps = 0; m_pp = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit h, input bit e);
    int nst, iv, x, fb;
    bit sp, pp, init;
    sp = s && !m_ps;
    pp = p && !m_pp;
    m_ps = s;
    m_pp = p;
    iv = C_BASE - m_level * C_STEP;
    if (iv < C_MIN) iv = C_MIN;
    nst = m_st;
    init = 0;
    m_req = 0;
    case (m_st)
      0: if (sp) init = 1;
      1: begin
        if (sp) init = 1;
        else if (m_cd == C_CD - 1) nst = 2;
        else m_cd++;
      end
      2: begin
        if (pp) nst = 3;
        if (h) begin
          m_hits++;
          if (m_hits == C_HPL) begin
            m_hits = 0;
            if (m_level < C_MAXL) m_level++;
          end
        end
        if (e) begin
          if (m_lives == 1) begin m_lives = 0; nst = 4; end
          else m_lives--;
        end
      end
      3: if (pp) nst = 2;
      default: if (sp) init = 1;
    endcase
    if (init) begin
      nst = 1; m_lives = C_LIVES; m_level = 0; m_hits = 0; m_cd = 0; m_cnt = 0;
    end
    if (m_st == 2 && nst == 2) begin
      if (m_cnt >= iv - 1) begin
        m_req = 1;
        x = m_lfsr % 32;
        m_sx = (x >= C_COLS) ? x - C_COLS : x;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
    m_st = nst;
  endtask

  task automatic compare_all();
    chk("state", state, m_st);
    chk("lives", lives, m_lives);
    chk("level", level, m_level);
    chk("spawn_req", spawn_req, m_req);
    if (m_req) chk("spawn_x", spawn_x, m_sx);
    chk("spawn_y", spawn_y, 0);
    chk("core_rst_n", core_rst_n, m_st != 0);
    chk("core_run", core_run, m_st == 2);
    chk("game_over", game_over, m_st == 4);
  endtask

  task automatic cyc(input bit s, input bit p, input bit h, input bit e);
    start_btn = s; pause_btn = p; hit = h; enemy_escape = e;
    model_step(s, p, h, e);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_core_rst_n"}, core_rst_n, 0);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_spawn_req"}, spawn_req, 0);
    chk({tag, "_spawn_x"}, spawn_x, 0);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_game_over"}, game_over, 0);
  endtask

  // Cycles between two consecutive spawn pulses, idle inputs; 0 on timeout.
  task automatic measure_gap(output int g);
    int n;
    g = 0;
    n = 0;
    while (!spawn_req && n < 200) begin cyc(0, 0, 0, 0); n++; end
    if (!spawn_req) return;
    n = 0;
    do begin cyc(0, 0, 0, 0); n++; end while (!spawn_req && n < 200);
    if (spawn_req) g = n;
  endtask

  initial begin
    int g, n;
    rst = 1'b1;
    start_btn = 0; pause_btn = 0; hit = 0; enemy_escape = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Start press at cycle 5.
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("cd_entry", state, 1);
    chk("cd_lives", lives, C_LIVES);
    repeat (C_CD - 1) cyc(1, 0, 0, 0);
    chk("still_cd", state, 1);
    cyc(0, 0, 0, 0);
    chk("play_entry", state, 2);
    chk("play_run", core_run, 1);

    // Level-0 cadence.
    measure_gap(g);
    chk("gap_lvl0", g, C_BASE);
    measure_gap(g);
    chk("gap_lvl0_b", g, C_BASE);

    // Five hits -> level 1, interval 36.
    for (int i = 0; i < C_HPL; i++) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end
    chk("level1", level, 1);
    measure_gap(g);
    chk("gap_lvl1", g, C_BASE - C_STEP);

    // 45 more hits (random spacing) -> saturate at 9, interval floor.
    n = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(0, 0, 1, 0);
      repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0);
    end
    chk("level_sat", level, C_MAXL);
    repeat (5) cyc(0, 0, 1, 0);
    chk("level_sat2", level, C_MAXL);
    measure_gap(g);
    chk("gap_floor", g, C_MIN);

    // Pause freeze: back to level 0 interval via restart is not possible in
    // PLAY, so freeze at count 5 of the floor interval instead of 20.
    n = 0;
    while (m_cnt != 5 && n < 100) begin cyc(0, 0, 0, 0); n++; end
    chk("pause_sync", m_cnt, 5);
    cyc(0, 1, 0, 0);
    chk("paused", state, 3);
    for (int i = 0; i < 100; i++) cyc(0, (i < 10), $urandom_range(0, 1), $urandom_range(0, 1));
    chk("pause_lives", lives, C_LIVES);
    cyc(0, 1, 0, 0);
    chk("resumed", state, 2);
    n = 0;
    while (!spawn_req && n < 100) begin cyc(0, 0, 0, 0); n++; end
    chk("resume_gap", n, C_MIN - 5);

    // Three escapes -> OVER.
    cyc(0, 0, 0, 1); chk("lives2", lives, 2);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("lives1", lives, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("lives0", lives, 0);
    chk("over_state", state, 4);
    chk("over_flag", game_over, 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin cyc(0, 0, 1, 1); if (spawn_req) n++; end
    chk("over_nospawn", n, 0);
    cyc(1, 0, 0, 0);
    chk("restart_state", state, 1);
    chk("restart_lives", lives, C_LIVES);
    chk("restart_level", level, 0);

    // Pause freeze at count 20 on the level-0 interval.
    repeat (C_CD) cyc(0, 0, 0, 0);
    n = 0;
    while (m_cnt != 20 && n < 100) begin cyc(0, 0, 0, 0); n++; end
    chk("pause20_sync", m_cnt, 20);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, (i < 5), $urandom_range(0, 1), $urandom_range(0, 1));
    cyc(0, 1, 0, 0);
    n = 0;
    while (!spawn_req && n < 100) begin cyc(0, 0, 0, 0); n++; end
    chk("resume20", n, 20);

    // Async reset mid-PLAY, raised between edges.
    repeat (7) cyc(0, 0, 0, 0);
    start_btn = 0; pause_btn = 0; hit = 0; enemy_escape = 0;
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Random traffic.
    begin
      bit s, p;
      s = 0; p = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 29) == 0) s = ~s;
        if ($urandom_range(0, 19) == 0) p = ~p;
        cyc(s, p, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_game_sequencer
`default_nettype wire
